// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (core/host) arbiter in front of a single-port data RAM,
//            with core priority and a starvation guard for the host port.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int addr_width   = 8,
    parameter int data_width   = 8,
    parameter int starve_limit = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [addr_width-1:0] core_addr,
    input  logic [data_width-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [data_width-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [addr_width-1:0] host_addr,
    input  logic [data_width-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [data_width-1:0] host_rdata,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam logic [3:0] c_starve_limit = 4'(starve_limit);

    owner_t                r_owner;
    logic [3:0]            r_starve_cnt;
    logic [data_width-1:0] r_core_hold;
    logic [data_width-1:0] r_host_hold;

    logic w_starved;
    logic w_host_win;
    logic w_core_win;

    // Grants are gated by reset so every strobe is quiet while reset is held.
    assign w_starved  = (r_starve_cnt == c_starve_limit);
    assign w_host_win = ~reset & host_req & (~core_req | w_starved);
    assign w_core_win = ~reset & core_req & ~w_host_win;

    assign core_gnt = w_core_win;
    assign host_gnt = w_host_win;

    always_comb begin
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        if (w_core_win) begin
            ram_read  = ~core_we;
            ram_write = core_we;
            ram_addr  = core_addr;
            ram_din   = core_wdata;
        end else if (w_host_win) begin
            ram_read  = ~host_we;
            ram_write = host_we;
            ram_addr  = host_addr;
            ram_din   = host_wdata;
        end
    end

    // Read data is passed straight through on the rvalid cycle and held after.
    assign core_rvalid = (r_owner == OWN_CORE);
    assign host_rvalid = (r_owner == OWN_HOST);
    assign core_rdata  = core_rvalid ? ram_dout : r_core_hold;
    assign host_rdata  = host_rvalid ? ram_dout : r_host_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= 4'd0;
            r_core_hold  <= '0;
            r_host_hold  <= '0;
        end else begin
            if (w_core_win && !core_we) begin
                r_owner <= OWN_CORE;
            end else if (w_host_win && !host_we) begin
                r_owner <= OWN_HOST;
            end else begin
                r_owner <= OWN_NONE;
            end

            if (!host_req || w_host_win) begin
                r_starve_cnt <= 4'd0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if (core_rvalid) begin
                r_core_hold <= ram_dout;
            end
            if (host_rvalid) begin
                r_host_hold <= ram_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scenario-driven bench for dmem_arbiter with a read-data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we, host_req, host_we;
    logic [7:0] core_addr, core_wdata, host_addr, host_wdata;
    logic       core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [7:0] core_rdata, host_rdata;
    logic       ram_read, ram_write;
    logic [7:0] ram_addr, ram_din;
    logic [7:0] ram_dout = 8'h00;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t       cq[$];
    exp_t       hq[$];
    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] last_c = 8'h00;
    logic [7:0] last_h = 8'h00;
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    dmem_arbiter #(
        .addr_width  (8),
        .data_width  (8),
        .starve_limit(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous single-port RAM, read data one cycle after ram_read.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        if (ram_read)  ram_dout <= mem[ram_addr];
    end

    // Scoreboard: read data due this cycle is popped and compared; otherwise
    // rvalid must be low and rdata must hold its last value.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            n_chk++;
            if (cq.size() > 0 && cq[0].due == cyc) begin
                e = cq.pop_front();
                if (core_rvalid !== 1'b1 || core_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL core_read cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                             cyc, core_rvalid, core_rdata, e.data);
                end
                last_c = e.data;
            end else if (core_rvalid !== 1'b0 || core_rdata !== last_c) begin
                n_fail++;
                $display("FAIL core_idle cyc=%0d got rvalid=%b rdata=%h want rvalid=0 rdata=%h",
                         cyc, core_rvalid, core_rdata, last_c);
            end
            n_chk++;
            if (hq.size() > 0 && hq[0].due == cyc) begin
                e = hq.pop_front();
                if (host_rvalid !== 1'b1 || host_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL host_read cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                             cyc, host_rvalid, host_rdata, e.data);
                end
                last_h = e.data;
            end else if (host_rvalid !== 1'b0 || host_rdata !== last_h) begin
                n_fail++;
                $display("FAIL host_idle cyc=%0d got rvalid=%b rdata=%h want rvalid=0 rdata=%h",
                         cyc, host_rvalid, host_rdata, last_h);
            end
        end
    end

    // Drives one cycle of requests, checks grant/RAM strobes, and records the
    // expected read data for a granted load.
    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                         input logic ec, input logic eh, input bit push, input string nm);
        logic       we;
        logic [7:0] ad, dn;
        exp_t       e;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        we = ec ? cw : (eh ? hw : 1'b0);
        ad = ec ? ca : (eh ? ha : 8'h00);
        dn = ec ? cd : (eh ? hd : 8'h00);
        #1;
        n_chk++;
        if ({core_gnt, host_gnt} !== {ec, eh}) begin
            n_fail++;
            $display("FAIL %s grant cyc=%0d got core=%b host=%b want core=%b host=%b",
                     nm, cyc, core_gnt, host_gnt, ec, eh);
        end
        n_chk++;
        if ({ram_read, ram_write, ram_addr, ram_din} !== {(ec | eh) & ~we, (ec | eh) & we, ad, dn}) begin
            n_fail++;
            $display("FAIL %s ram cyc=%0d got rd=%b wr=%b addr=%h din=%h want rd=%b wr=%b addr=%h din=%h",
                     nm, cyc, ram_read, ram_write, ram_addr, ram_din, (ec | eh) & ~we, (ec | eh) & we, ad, dn);
        end
        if ((ec | eh) && we) exp_mem[ad] = dn;
        if ((ec | eh) && !we && push) begin
            e.due  = cyc + 1;
            e.data = exp_mem[ad];
            if (ec) cq.push_back(e);
            else    hq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, "idle");
    endtask

    task automatic check_reset_outputs(input string nm);
        n_chk++;
        if ({core_gnt, host_gnt, ram_read, ram_write, core_rvalid, host_rvalid} !== 6'b0 ||
            {ram_addr, ram_din, core_rdata, host_rdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got gnt=%b%b rw=%b%b rv=%b%b addr=%h din=%h rd=%h/%h want all zero",
                     nm, cyc, core_gnt, host_gnt, ram_read, ram_write, core_rvalid, host_rvalid,
                     ram_addr, ram_din, core_rdata, host_rdata);
        end
    endtask

    task automatic test_reset;
        core_req = 1; core_we = 0; core_addr = 8'h10; core_wdata = 8'hAA;
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hBB;
        #1;
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        drive(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 1, "first_grant");
    endtask

    task automatic test_core_only;
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, "core_load");
        idle(2);
    endtask

    task automatic test_idle;
        idle(4);
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, "alt_core");
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 1, "alt_host");
        drive(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, "alt_core2");
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h77, 0, 1, 1, "host_store");
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 1, 1, "host_load");
        idle(2);
    endtask

    task automatic test_contention;
        for (int i = 1; i <= 10; i++)
            drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, (i != 5 && i != 10), (i == 5 || i == 10), 1, "contend");
        idle(2);
    endtask

    task automatic test_starve_drop;
        for (int i = 0; i < 2; i++)
            drive(1, 1, 8'h50, 8'(8'h60 + i), 1, 1, 8'h40, 8'h99, 1, 0, 1, "drop_pre");
        drive(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, "drop_gap");
        for (int i = 1; i <= 5; i++)
            drive(1, 0, 8'h01, 8'h00, 1, 1, 8'h40, 8'h99, (i != 5), (i == 5), 1, "drop_restart");
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0, 1, 1, "drop_readback");
        idle(2);
    endtask

    task automatic test_reset_midread;
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, "midread_load");
        reset  = 1'b1;
        last_c = 8'h00;
        last_h = 8'h00;
        core_req = 1; host_req = 1;
        #1;
        check_reset_outputs("midread_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("midread_reset2");
        reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 0, 1, 1, "post_reset");
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        mem[1] = 8'h11; exp_mem[1] = 8'h11;
        mem[2] = 8'h22; exp_mem[2] = 8'h22;
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 8'h00; core_wdata = 8'h00;
        host_req = 0; host_we = 0; host_addr = 8'h00; host_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        test_reset;
        test_core_only;
        test_idle;
        test_back_to_back;
        test_contention;
        test_starve_drop;
        test_reset_midread;
        n_chk++;
        if (cq.size() != 0 || hq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got core_pending=%0d host_pending=%0d want 0/0", cq.size(), hq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
